// File: rtl/ascon_hash_pkg.sv
// ---------------------------------------------------------------------------
// ascon_hash_pkg
//   Shared definitions for the Hash core wrappers and the hash_scheduler:
//   scheduler FSM state type, default message/digest widths and a small
//   one-hot helper for the two-requester datapath.
// ---------------------------------------------------------------------------
package ascon_hash_pkg;

  localparam int unsigned HASH_Y_DEFAULT = 40;   // message width (bits)
  localparam int unsigned HASH_L_DEFAULT = 256;  // digest width (bits)

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    WAIT,
    DELIVER
  } hs_state_t;

  // Requester index (0/1) to one-hot two-bit vector.
  function automatic logic [1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. Grant is combinational from the request
//   vector; the priority pointer is registered and advanced by the parent
//   once a requester has been served.
//
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (priority to requester 0)
//   i_req      : request vector, one bit per requester
//   i_update   : a request has completed; advance the pointer
//   i_served   : index of the requester that was just served
//   o_grant    : one-hot grant (all zero when nothing requested)
//   o_grant_id : index of the granted requester (0 when nothing requested)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import ascon_hash_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  // r_prio holds the requester that wins the next tie, i.e. the one that
  // was NOT served last. Resetting it to 0 gives requester 0 the first tie.
  logic r_prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (i_update) begin
      r_prio <= ~i_served;
    end
  end

  always_comb begin
    o_grant_id = 1'b0;
    o_grant    = '0;
    case (i_req)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = r_prio;
      default: o_grant_id = 1'b0;
    endcase
    if (|i_req) begin
      o_grant = onehot2(o_grant_id);
    end
  end

endmodule

// File: rtl/hash_scheduler.sv
// ---------------------------------------------------------------------------
// hash_scheduler
//   Shares one Hash core between two requesters. Accepts a request in IDLE
//   (round-robin on contention), starts the core, waits for completion with
//   a bounded timeout and hands the digest back to the granted requester.
//
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   req_valid[1:0]: per-requester hash request
//   req_msg0/1    : message of requester 0 / 1 (Y bits)
//   req_ready[1:0]: one-cycle accept pulse to the granted requester
//   rsp_valid[1:0]: digest available for the granted requester
//   rsp_ready[1:0]: requester consumes the digest
//   rsp_digest    : digest of the served request (L bits)
//   err           : sticky core-timeout flag, cleared only by reset
//   core_message  : message presented to the Hash core
//   core_start    : one-cycle start pulse to the Hash core
//   core_ready    : Hash core done (level)
//   core_digest   : Hash core digest
// ---------------------------------------------------------------------------
module hash_scheduler
  import ascon_hash_pkg::*;
#(
  parameter int unsigned Y       = HASH_Y_DEFAULT,
  parameter int unsigned L       = HASH_L_DEFAULT,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  input  logic [Y-1:0] req_msg0,
  input  logic [Y-1:0] req_msg1,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [L-1:0] rsp_digest,
  output logic         err,
  output logic [Y-1:0] core_message,
  output logic         core_start,
  input  logic         core_ready,
  input  logic [L-1:0] core_digest
);

  localparam int unsigned   CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  hs_state_t     r_state;
  hs_state_t     w_state_nxt;
  logic          r_gnt;        // requester owning the current transaction
  logic [CW-1:0] r_cnt;        // WAIT cycles without completion

  logic [1:0]    w_arb_grant;
  logic          w_arb_id;
  logic          w_served;
  logic          w_capture;
  logic          w_timeout;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_update   (w_served),
    .i_served   (r_gnt),
    .o_grant    (w_arb_grant),
    .o_grant_id (w_arb_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_served    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    core_start  = 1'b0;

    case (r_state)
      IDLE: begin
        // Gated by rst so no accept is signalled in a cycle that reset discards.
        if (!rst) begin
          req_ready = w_arb_grant;
        end
        if (|req_valid) begin
          w_state_nxt = START;
        end
      end
      START: begin
        core_start  = 1'b1;
        w_state_nxt = ARM;
      end
      ARM: begin
        // core_ready may still be high from the previous hash; skip it.
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Completion takes precedence over an expiring timeout.
        if (core_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = DELIVER;
        end else if (r_cnt == CNT_MAX) begin
          w_timeout   = 1'b1;
          w_served    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DELIVER: begin
        rsp_valid = onehot2(r_gnt);
        if (rsp_ready[r_gnt]) begin
          w_served    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      rsp_digest   <= '0;
      err          <= 1'b0;
      core_message <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == IDLE) && (|req_valid)) begin
        r_gnt        <= w_arb_id;
        core_message <= w_arb_id ? req_msg1 : req_msg0;
      end

      if (r_state == START) begin
        r_cnt <= '0;
      end else if ((r_state == WAIT) && !core_ready && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_capture) begin
        rsp_digest <= core_digest;
      end

      if (w_timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hash_scheduler.sv
module tb_hash_scheduler;

  localparam int unsigned Y = 40;
  localparam int unsigned L = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid;
  logic [Y-1:0] req_msg0;
  logic [Y-1:0] req_msg1;
  logic [1:0]   rsp_ready;
  logic         core_ready;
  logic [L-1:0] core_digest;

  // Default-TIMEOUT instance
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [L-1:0] rsp_digest;
  logic         err;
  logic [Y-1:0] core_message;
  logic         core_start;

  // TIMEOUT=15 instance, same inputs
  logic [1:0]   t_req_ready;
  logic [1:0]   t_rsp_valid;
  logic [L-1:0] t_rsp_digest;
  logic         t_err;
  logic [Y-1:0] t_core_message;
  logic         t_core_start;

  int checks = 0;
  int fails  = 0;

  localparam logic [L-1:0] D1 = {8{32'hDEADBEEF}};
  localparam logic [L-1:0] DS = {8{32'h5A5A0000}};
  localparam logic [L-1:0] DN = {8{32'h0123ABCD}};
  localparam logic [L-1:0] DX = {8{32'hFFFF0001}};
  localparam logic [L-1:0] DZ = {8{32'h77777777}};
  localparam logic [L-1:0] DB = {8{32'hB0B0CAFE}};
  localparam logic [L-1:0] DT = {8{32'h1E1E2F2F}};
  localparam logic [Y-1:0] M0 = 40'hAA_0000_0001;
  localparam logic [Y-1:0] M1 = 40'hBB_0000_0002;
  localparam logic [Y-1:0] MS = 40'h12_3456_789A;

  hash_scheduler #(.Y(Y), .L(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_msg0(req_msg0), .req_msg1(req_msg1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_digest(rsp_digest), .err(err), .core_message(core_message),
    .core_start(core_start), .core_ready(core_ready), .core_digest(core_digest)
  );

  hash_scheduler #(.Y(Y), .L(L), .TIMEOUT(15)) dut_t (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_msg0(req_msg0), .req_msg1(req_msg1),
    .req_ready(t_req_ready), .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_digest(t_rsp_digest), .err(t_err), .core_message(t_core_message),
    .core_start(t_core_start), .core_ready(core_ready), .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_msg0 = '0; req_msg1 = '0;
    core_ready = 1'b0; core_digest = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 2'b00); end
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 2'b00); end
    checks++; if (rsp_digest !== '0) begin fails++; $display("FAIL reset_rsp_digest: got %h expected 0", rsp_digest); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (core_message !== '0) begin fails++; $display("FAIL reset_core_message: got %h expected 0", core_message); end
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL reset_core_start: got %b expected 0", core_start); end
  endtask

  task automatic test_single;
    req_msg0 = 40'h0; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_accept: got %b expected %b", req_ready, 2'b01); end
    tick; req_valid = 2'b00;  // START
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL single_accept_pulse: got %b expected %b", req_ready, 2'b00); end
    checks++; if (core_start !== 1'b1) begin fails++; $display("FAIL single_core_start: got %b expected 1", core_start); end
    checks++; if (core_message !== 40'h0) begin fails++; $display("FAIL single_core_message: got %h expected 0", core_message); end
    tick;  // ARM
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL single_start_one_cycle: got %b expected 0", core_start); end
    repeat (19) tick;  // 20 cycles after the start pulse
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_no_early_rsp: got %b expected %b", rsp_valid, 2'b00); end
    core_ready = 1'b1; core_digest = D1;
    tick; core_ready = 1'b0; core_digest = '0;
    #1;
    checks++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, 2'b01); end
    checks++; if (rsp_digest !== D1) begin fails++; $display("FAIL single_rsp_digest: got %h expected %h", rsp_digest, D1); end
    rsp_ready = 2'b01;
    tick; rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_rsp_release: got %b expected %b", rsp_valid, 2'b00); end
  endtask

  // Pointer favours requester 1 here; a lone request from 0 must still win.
  // core_ready stays high from START on; only the WAIT-cycle digest counts.
  task automatic test_stale_ready;
    core_ready = 1'b1; core_digest = DS; req_msg0 = MS; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_valid_wins: got %b expected %b", req_ready, 2'b01); end
    tick; req_valid = 2'b00;  // N+1
    checks++; if (core_start !== 1'b1) begin fails++; $display("FAIL lat_start_n1: got %b expected 1", core_start); end
    checks++; if (core_message !== MS) begin fails++; $display("FAIL stale_core_message: got %h expected %h", core_message, MS); end
    tick;  // N+2 ARM
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL stale_start_n2: got %b expected 0", core_start); end
    tick;  // N+3 WAIT
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL stale_ready_in_arm: got %b expected %b", rsp_valid, 2'b00); end
    core_digest = DN;
    tick;  // N+4 DELIVER
    checks++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL lat_rsp_n4: got %b expected %b", rsp_valid, 2'b01); end
    checks++; if (rsp_digest !== DN) begin fails++; $display("FAIL stale_digest_from_wait: got %h expected %h", rsp_digest, DN); end
    core_ready = 1'b0;
  endtask

  task automatic test_stall;
    rsp_ready = 2'b10; req_valid = 2'b11; core_ready = 1'b1; core_digest = DX;
    req_msg0 = M0; req_msg1 = M1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL stall_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, 2'b01); end
      checks++; if (rsp_digest !== DN) begin fails++; $display("FAIL stall_rsp_digest[%0d]: got %h expected %h", i, rsp_digest, DN); end
      checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL stall_core_start[%0d]: got %b expected 0", i, core_start); end
      checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL stall_req_ready[%0d]: got %b expected %b", i, req_ready, 2'b00); end
    end
    rsp_ready = 2'b11;
    tick;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL stall_release: got %b expected %b", rsp_valid, 2'b00); end
  endtask

  // Last served was 0, so the sequence starts with 1 and alternates.
  task automatic test_contention;
    logic [1:0]   exp_g [4];
    logic [31:0]  word;
    logic [Y-1:0] exp_msg;
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      word = 32'hC0DE0000 + 32'(k);
      core_digest = {8{word}};
      exp_msg = (exp_g[k] == 2'b10) ? M1 : M0;
      #1;
      checks++; if (req_ready !== exp_g[k]) begin fails++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_g[k]); end
      tick;
      checks++; if (core_message !== exp_msg) begin fails++; $display("FAIL contention_msg[%0d]: got %h expected %h", k, core_message, exp_msg); end
      tick; tick; tick;
      checks++; if (rsp_valid !== exp_g[k]) begin fails++; $display("FAIL contention_rsp[%0d]: got %b expected %b", k, rsp_valid, exp_g[k]); end
      checks++; if (rsp_digest !== {8{word}}) begin fails++; $display("FAIL contention_digest[%0d]: got %h expected %h", k, rsp_digest, {8{word}}); end
      checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL b2b_no_grant_deliver[%0d]: got %b expected %b", k, req_ready, 2'b00); end
      if (k == 3) req_valid = 2'b00;
      tick;
    end
    rsp_ready = 2'b00; core_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 2'b10;
    #1;
    tick; req_valid = 2'b00;
    tick; tick; tick; tick;  // in WAIT
    rst = 1'b1;
    tick; rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL midrst_req_ready: got %b expected %b", req_ready, 2'b00); end
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_rsp_valid: got %b expected %b", rsp_valid, 2'b00); end
    checks++; if (rsp_digest !== '0) begin fails++; $display("FAIL midrst_rsp_digest: got %h expected 0", rsp_digest); end
    checks++; if (core_message !== '0) begin fails++; $display("FAIL midrst_core_message: got %h expected 0", core_message); end
    checks++; if (core_start !== 1'b0) begin fails++; $display("FAIL midrst_core_start: got %b expected 0", core_start); end
    core_ready = 1'b1; core_digest = DZ;
    tick; core_ready = 1'b0;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_ignore_ready_a: got %b expected %b", rsp_valid, 2'b00); end
    tick;
    checks++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_ignore_ready_b: got %b expected %b", rsp_valid, 2'b00); end
    checks++; if (rsp_digest !== '0) begin fails++; $display("FAIL midrst_digest_kept: got %h expected 0", rsp_digest); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL tie_after_reset: got %b expected %b", req_ready, 2'b01); end
    req_valid = 2'b00;
  endtask

  // TIMEOUT=15 instance: completion on the final allowed WAIT cycle wins.
  task automatic test_timeout_boundary;
    rst = 1'b1; core_ready = 1'b0; rsp_ready = 2'b00;
    tick; rst = 1'b0;
    req_valid = 2'b10;
    #1;
    tick; req_valid = 2'b00;
    tick; tick;          // WAIT, count 0
    repeat (15) tick;    // WAIT, count 15
    checks++; if (t_rsp_valid !== 2'b00) begin fails++; $display("FAIL tobound_waiting: got %b expected %b", t_rsp_valid, 2'b00); end
    checks++; if (t_err !== 1'b0) begin fails++; $display("FAIL tobound_err_early: got %b expected 0", t_err); end
    core_ready = 1'b1; core_digest = DB;
    tick; core_ready = 1'b0;
    checks++; if (t_rsp_valid !== 2'b10) begin fails++; $display("FAIL tobound_rsp_valid: got %b expected %b", t_rsp_valid, 2'b10); end
    checks++; if (t_rsp_digest !== DB) begin fails++; $display("FAIL tobound_digest: got %h expected %h", t_rsp_digest, DB); end
    checks++; if (t_err !== 1'b0) begin fails++; $display("FAIL tobound_err: got %b expected 0", t_err); end
    rsp_ready = 2'b10;
    tick; rsp_ready = 2'b00;
  endtask

  // Requester 1 was served last, so after a timeout on requester 0 the next
  // tie must go to 1 only if the timed-out request counted as served.
  task automatic test_timeout;
    req_valid = 2'b01;
    #1;
    tick; req_valid = 2'b00;
    tick; tick;          // WAIT, count 0
    repeat (15) tick;
    checks++; if (t_err !== 1'b0) begin fails++; $display("FAIL timeout_not_early: got %b expected 0", t_err); end
    tick;
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1", t_err); end
    checks++; if (t_rsp_valid !== 2'b00) begin fails++; $display("FAIL timeout_no_rsp: got %b expected %b", t_rsp_valid, 2'b00); end
    checks++; if (t_core_start !== 1'b0) begin fails++; $display("FAIL timeout_idle: got %b expected 0", t_core_start); end
    req_valid = 2'b11;
    #1;
    checks++; if (t_req_ready !== 2'b10) begin fails++; $display("FAIL timeout_served_ptr: got %b expected %b", t_req_ready, 2'b10); end
    tick; req_valid = 2'b00;
    checks++; if (t_core_start !== 1'b1) begin fails++; $display("FAIL timeout_next_start: got %b expected 1", t_core_start); end
    core_ready = 1'b1; core_digest = DT;
    tick; tick; tick;
    checks++; if (t_rsp_valid !== 2'b10) begin fails++; $display("FAIL timeout_next_rsp: got %b expected %b", t_rsp_valid, 2'b10); end
    checks++; if (t_rsp_digest !== DT) begin fails++; $display("FAIL timeout_next_digest: got %h expected %h", t_rsp_digest, DT); end
    rsp_ready = 2'b10;
    tick; rsp_ready = 2'b00; core_ready = 1'b0;
    checks++; if (t_err !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky: got %b expected 1", t_err); end
    checks++; if (t_rsp_valid !== 2'b00) begin fails++; $display("FAIL timeout_next_release: got %b expected %b", t_rsp_valid, 2'b00); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stale_ready;
    test_stall;
    test_contention;
    test_reset_mid_wait;
    test_timeout_boundary;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
